// File: rtl/mem_pkg.sv
// Shared encodings and limits for the core-side memory controller.
// No logic; constants, state enum and small decode helpers only.
// Backpressure: not applicable.
package mem_pkg;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_LB   = 3'b001;
    localparam logic [2:0] RD_LH   = 3'b010;
    localparam logic [2:0] RD_LW   = 3'b011;
    localparam logic [2:0] RD_LBU  = 3'b101;
    localparam logic [2:0] RD_LHU  = 3'b110;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_SB   = 2'b01;
    localparam logic [1:0] WR_SH   = 2'b10;
    localparam logic [1:0] WR_SW   = 2'b11;

    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 4;
    localparam int CNT_W       = 2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_e;

    function automatic logic rd_op_legal(input logic [2:0] op);
        return !(op == 3'b100 || op == 3'b111);
    endfunction

    function automatic logic [1:0] rd_size(input logic [2:0] op);
        case (op)
            RD_LH, RD_LHU: return SZ_HALF;
            RD_LW:         return SZ_WORD;
            default:       return SZ_BYTE;
        endcase
    endfunction

    function automatic logic [1:0] wr_size(input logic [1:0] op);
        case (op)
            WR_SH:   return SZ_HALF;
            WR_SW:   return SZ_WORD;
            default: return SZ_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication/byte enables and load lane select/extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  wr_op,
    input  logic [1:0]  wr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data,
    input  logic [2:0]  rd_op,
    input  logic [1:0]  rd_lo,
    input  logic [31:0] ram_rdata,
    output logic [31:0] rd_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = wdata;
        case (wr_op)
            WR_SB: begin
                wr_be   = 4'b0001 << wr_lo;
                wr_data = {4{wdata[7:0]}};
            end
            WR_SH: begin
                wr_be   = 4'b0011 << wr_lo;
                wr_data = {2{wdata[15:0]}};
            end
            WR_SW: begin
                wr_be   = 4'b1111;
                wr_data = wdata;
            end
            default: ;
        endcase
    end

    // Halfword loads are always aligned, so bit 1 alone picks the half.
    assign half_sel = rd_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    assign byte_sel = rd_lo[0] ? half_sel[15:8]   : half_sel[7:0];

    always_comb begin
        rd_data = 32'd0;
        case (rd_op)
            RD_LB:   rd_data = {{24{byte_sel[7]}}, byte_sel};
            RD_LBU:  rd_data = {24'd0, byte_sel};
            RD_LH:   rd_data = {{16{half_sel[15]}}, half_sel};
            RD_LHU:  rd_data = {16'd0, half_sel};
            RD_LW:   rd_data = ram_rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding memory controller between the RV32 core and a word-wide sync RAM.
// Latency: store/fault 1 cycle to mem_ready, load RAM_LATENCY+1 cycles.
// Backpressure: mem_init only sampled in IDLE; strobes in other states are dropped.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_init,
    input  logic [2:0]        mem_read_op,
    input  logic [1:0]        mem_write_op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mem_ready,
    output logic              bus_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int LAT_C = (RAM_LATENCY < RAM_LAT_MIN) ? RAM_LAT_MIN :
                           (RAM_LATENCY > RAM_LAT_MAX) ? RAM_LAT_MAX : RAM_LATENCY;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT_C - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         ld_op_q;
    logic [1:0]         ld_lo_q;
    logic [31:0]        rdata_q;
    logic               ready_q;
    logic               err_q;

    logic               is_rd, is_wr;
    logic               op_err, size_err, range_err, fault, accept;
    logic [1:0]         acc_size;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic [31:0]        ld_data;

    always_comb begin
        is_rd     = (mem_read_op != RD_NONE);
        is_wr     = (mem_write_op != WR_NONE);
        op_err    = (is_rd == is_wr) || !rd_op_legal(mem_read_op);
        acc_size  = is_rd ? rd_size(mem_read_op) : wr_size(mem_write_op);
        size_err  = ((acc_size == SZ_HALF) && addr[0]) ||
                    ((acc_size == SZ_WORD) && (addr[1:0] != 2'b00));
        range_err = ((addr >> (ADDR_W + 2)) != 32'd0);
        fault     = op_err || size_err || range_err;
        accept    = (state_q == ST_IDLE) && mem_init;
    end

    // RAM strobes are driven straight from the request in the accept cycle.
    assign ram_en    = accept && !fault;
    assign ram_we    = (ram_en && is_wr) ? wr_be : 4'b0000;
    assign ram_addr  = addr[ADDR_W+1:2];
    assign ram_wdata = wr_data;

    mem_lane_align u_align (
        .wr_op     (mem_write_op),
        .wr_lo     (addr[1:0]),
        .wdata     (wdata),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .rd_op     (ld_op_q),
        .rd_lo     (ld_lo_q),
        .ram_rdata (ram_rdata),
        .rd_data   (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ld_op_q <= RD_NONE;
            ld_lo_q <= 2'b00;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_init) begin
                        if (fault) begin
                            state_q <= ST_RESP;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end else if (is_wr) begin
                            state_q <= ST_RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_RD_WAIT;
                            cnt_q   <= CNT_INIT;
                            ld_op_q <= mem_read_op;
                            ld_lo_q <= addr[1:0];
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q <= ld_data;
                        state_q <= ST_RESP;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign mem_ready = ready_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table, latency/reset sequences, random vs byte-level model.
// Two instances: RAM_LATENCY=1 and RAM_LATENCY=3, each with its own behavioural RAM.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init1, init3;
    logic [2:0]  rop;
    logic [1:0]  wop;
    logic [31:0] a, wd;

    logic [31:0] rdata1, rdata3, rwd1, rwd3, rrd1, rrd3;
    logic        ready1, ready3, err1, err3, en1, en3;
    logic [3:0]  we1, we3;
    logic [11:0] ra1, ra3;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(12), .RAM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .mem_init(init1), .mem_read_op(rop), .mem_write_op(wop),
        .addr(a), .wdata(wd), .rdata(rdata1), .mem_ready(ready1), .bus_err(err1),
        .ram_en(en1), .ram_we(we1), .ram_addr(ra1), .ram_wdata(rwd1), .ram_rdata(rrd1));

    mem_ctrl #(.ADDR_W(12), .RAM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(rst_n), .mem_init(init3), .mem_read_op(rop), .mem_write_op(wop),
        .addr(a), .wdata(wd), .rdata(rdata3), .mem_ready(ready3), .bus_err(err3),
        .ram_en(en3), .ram_we(we3), .ram_addr(ra3), .ram_wdata(rwd3), .ram_rdata(rrd3));

    logic [31:0] ram1 [0:4095];
    logic [31:0] ram3 [0:4095];
    logic [31:0] p_dat [0:1];
    logic [1:0]  p_vld;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (en1) begin
            if (we1 != 4'b0) ram1[ra1] <= merge(ram1[ra1], rwd1, we1);
            else             rrd1 <= ram1[ra1];
        end
    end

    // Three-stage read pipe; output register holds until the next read emerges.
    always @(posedge clk) begin
        p_vld    <= {p_vld[0], en3 && (we3 == 4'b0)};
        p_dat[0] <= ram3[ra3];
        p_dat[1] <= p_dat[0];
        if (p_vld[1]) rrd3 <= p_dat[1];
        if (en3 && we3 != 4'b0) ram3[ra3] <= merge(ram3[ra3], rwd3, we3);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic req(input bit s3, input logic [2:0] r, input logic [1:0] w,
                       input logic [31:0] ad, input logic [31:0] d,
                       output logic en0, output logic [3:0] we0, output logic [11:0] ra0,
                       output logic [31:0] wd0, output logic [31:0] rd, output logic er,
                       output int lat);
        @(negedge clk);
        rop = r; wop = w; a = ad; wd = d;
        if (s3) init3 = 1'b1; else init1 = 1'b1;
        #1;
        en0 = s3 ? en3 : en1;
        we0 = s3 ? we3 : we1;
        ra0 = s3 ? ra3 : ra1;
        wd0 = s3 ? rwd3 : rwd1;
        @(negedge clk);
        init1 = 1'b0; init3 = 1'b0;
        lat = -1; rd = 32'd0; er = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (s3 ? ready3 : ready1) begin
                lat = c;
                rd  = s3 ? rdata3 : rdata1;
                er  = s3 ? err3 : err1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]  r;
        logic [1:0]  w;
        logic [31:0] ad;
        logic [31:0] d;
        logic        e_en;
        logic [3:0]  e_we;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
    } vec_t;

    function automatic vec_t mkv(input logic [2:0] r, input logic [1:0] w, input logic [31:0] ad,
                                 input logic [31:0] d, input logic en, input logic [3:0] we,
                                 input logic [31:0] wdv, input logic [31:0] rd, input logic err,
                                 input int lat);
        vec_t v;
        v.r = r; v.w = w; v.ad = ad; v.d = d; v.e_en = en; v.e_we = we;
        v.e_wd = wdv; v.e_rd = rd; v.e_err = err; v.e_lat = lat;
        return v;
    endfunction

    vec_t        vt [$];
    logic        g_en, g_er;
    logic [3:0]  g_we;
    logic [11:0] g_ra;
    logic [31:0] g_wd, g_rd;
    int          g_lat;

    logic [7:0]  refm [0:1][0:511];
    logic [31:0] last_rd [0:1];
    logic [2:0]  legal_rd [0:4];
    logic [2:0]  rr;
    logic [1:0]  rw;
    logic [31:0] ra_r, rd_r, exp_rd;
    logic [3:0]  exp_we;
    bit          s3, flt;
    int          nb, ai, k;

    initial begin
        for (int i = 0; i < 4096; i++) begin ram1[i] = 32'd0; ram3[i] = 32'd0; end
        for (int i = 0; i < 512; i++) begin refm[0][i] = 8'd0; refm[1][i] = 8'd0; end
        p_vld = 2'b00; rrd1 = 32'd0; rrd3 = 32'd0;
        rst_n = 1'b0; init1 = 1'b0; init3 = 1'b0;
        rop = 3'b000; wop = 2'b00; a = 32'd0; wd = 32'd0;

        repeat (3) @(negedge clk);
        chk("reset.rdata1", rdata1, 32'd0);
        chk("reset.ready1", {31'd0, ready1}, 32'd0);
        chk("reset.err1", {31'd0, err1}, 32'd0);
        chk("reset.rdata3", rdata3, 32'd0);
        chk("reset.ready3", {31'd0, ready3}, 32'd0);
        rst_n = 1'b1;

        // Directed table on the latency-1 instance, issued back to back.
        vt.push_back(mkv(3'b000, 2'b11, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0, 1));
        vt.push_back(mkv(3'b011, 2'b00, 32'h10, 32'h0, 1, 4'h0, 32'h0, 32'hDEADBEEF, 0, 2));
        vt.push_back(mkv(3'b000, 2'b01, 32'h13, 32'h000000A5, 1, 4'h8, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 1));
        vt.push_back(mkv(3'b001, 2'b00, 32'h13, 32'h0, 1, 4'h0, 32'h0, 32'hFFFFFFA5, 0, 2));
        vt.push_back(mkv(3'b101, 2'b00, 32'h13, 32'h0, 1, 4'h0, 32'h0, 32'h000000A5, 0, 2));
        // bytes 3:2 of word 0xA5ADBEEF
        vt.push_back(mkv(3'b010, 2'b00, 32'h12, 32'h0, 1, 4'h0, 32'h0, 32'hFFFFA5AD, 0, 2));
        vt.push_back(mkv(3'b011, 2'b00, 32'h10, 32'h0, 1, 4'h0, 32'h0, 32'hA5ADBEEF, 0, 2));
        vt.push_back(mkv(3'b000, 2'b10, 32'h12, 32'hFFFF1234, 1, 4'hC, 32'h12341234, 32'hA5ADBEEF, 0, 1));
        vt.push_back(mkv(3'b110, 2'b00, 32'h12, 32'h0, 1, 4'h0, 32'h0, 32'h00001234, 0, 2));
        vt.push_back(mkv(3'b010, 2'b00, 32'h10, 32'h0, 1, 4'h0, 32'h0, 32'hFFFFBEEF, 0, 2));
        vt.push_back(mkv(3'b110, 2'b00, 32'h10, 32'h0, 1, 4'h0, 32'h0, 32'h0000BEEF, 0, 2));
        vt.push_back(mkv(3'b000, 2'b01, 32'h11, 32'hFFFFFF3C, 1, 4'h2, 32'h3C3C3C3C, 32'h0000BEEF, 0, 1));
        vt.push_back(mkv(3'b001, 2'b00, 32'h11, 32'h0, 1, 4'h0, 32'h0, 32'h0000003C, 0, 2));
        vt.push_back(mkv(3'b011, 2'b00, 32'h10, 32'h0, 1, 4'h0, 32'h0, 32'h12343CEF, 0, 2));
        vt.push_back(mkv(3'b010, 2'b00, 32'h11, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1));
        vt.push_back(mkv(3'b011, 2'b00, 32'h10, 32'h0, 1, 4'h0, 32'h0, 32'h12343CEF, 0, 2));
        vt.push_back(mkv(3'b000, 2'b11, 32'h2, 32'h11111111, 0, 4'h0, 32'h0, 32'h0, 1, 1));
        vt.push_back(mkv(3'b011, 2'b00, 32'h4000, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1));
        vt.push_back(mkv(3'b111, 2'b00, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1));
        vt.push_back(mkv(3'b011, 2'b11, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1));
        vt.push_back(mkv(3'b000, 2'b00, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1));
        vt.push_back(mkv(3'b101, 2'b00, 32'h10, 32'h0, 1, 4'h0, 32'h0, 32'h000000EF, 0, 2));
        vt.push_back(mkv(3'b000, 2'b01, 32'h4000, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1));
        vt.push_back(mkv(3'b000, 2'b11, 32'h3FFC, 32'h89ABCDEF, 1, 4'hF, 32'h89ABCDEF, 32'h0, 0, 1));
        vt.push_back(mkv(3'b110, 2'b00, 32'h3FFE, 32'h0, 1, 4'h0, 32'h0, 32'h000089AB, 0, 2));
        vt.push_back(mkv(3'b010, 2'b00, 32'h3FFE, 32'h0, 1, 4'h0, 32'h0, 32'hFFFF89AB, 0, 2));

        foreach (vt[i]) begin
            req(1'b0, vt[i].r, vt[i].w, vt[i].ad, vt[i].d, g_en, g_we, g_ra, g_wd, g_rd, g_er, g_lat);
            chk($sformatf("vec%0d.ram_en", i), {31'd0, g_en}, {31'd0, vt[i].e_en});
            chk($sformatf("vec%0d.ram_we", i), {28'd0, g_we}, {28'd0, vt[i].e_we});
            if (vt[i].e_en)
                chk($sformatf("vec%0d.ram_addr", i), {20'd0, g_ra}, {20'd0, vt[i].ad[13:2]});
            if (vt[i].e_we != 4'h0)
                chk($sformatf("vec%0d.ram_wdata", i), g_wd, vt[i].e_wd);
            chk($sformatf("vec%0d.latency", i), 32'(g_lat), 32'(vt[i].e_lat));
            chk($sformatf("vec%0d.bus_err", i), {31'd0, g_er}, {31'd0, vt[i].e_err});
            chk($sformatf("vec%0d.rdata", i), g_rd, vt[i].e_rd);
        end

        // Latency-3 load with strobes held during the wait.
        req(1'b1, 3'b000, 2'b11, 32'h20, 32'hCAFEF00D, g_en, g_we, g_ra, g_wd, g_rd, g_er, g_lat);
        chk("l3.sw.latency", 32'(g_lat), 32'd1);
        chk("l3.sw.ram_we", {28'd0, g_we}, 32'hF);
        @(negedge clk);
        rop = 3'b011; wop = 2'b00; a = 32'h20; init3 = 1'b1;
        #1 chk("l3.c0.ram_en", {31'd0, en3}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("l3.c%0d.ram_en", c), {31'd0, en3}, 32'd0);
            chk($sformatf("l3.c%0d.ram_we", c), {28'd0, we3}, 32'd0);
            chk($sformatf("l3.c%0d.ready", c), {31'd0, ready3}, 32'd0);
        end
        @(negedge clk);
        init3 = 1'b0;
        #1;
        chk("l3.c4.ready", {31'd0, ready3}, 32'd1);
        chk("l3.c4.rdata", rdata3, 32'hCAFEF00D);
        chk("l3.c4.bus_err", {31'd0, err3}, 32'd0);
        for (int c = 5; c <= 8; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("l3.c%0d.ready", c), {31'd0, ready3}, 32'd0);
            chk($sformatf("l3.c%0d.ram_en", c), {31'd0, en3}, 32'd0);
        end

        // Reset pulled in cycle 1 of a load; the load must vanish.
        @(negedge clk);
        rop = 3'b011; wop = 2'b00; a = 32'h10; init1 = 1'b1;
        #1 chk("rst.c0.ram_en", {31'd0, en1}, 32'd1);
        @(negedge clk);
        init1 = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst.c1.rdata", rdata1, 32'd0);
        chk("rst.c1.ready", {31'd0, ready1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            #1 chk($sformatf("rst.c%0d.ready", c), {31'd0, ready1}, 32'd0);
            @(negedge clk);
        end
        chk("rst.after.rdata", rdata1, 32'd0);
        req(1'b0, 3'b011, 2'b00, 32'h10, 32'h0, g_en, g_we, g_ra, g_wd, g_rd, g_er, g_lat);
        chk("rst.fresh.latency", 32'(g_lat), 32'd2);
        chk("rst.fresh.rdata", g_rd, 32'h12343CEF);

        // Random traffic against a byte-addressed model of memory.
        last_rd[0] = 32'h12343CEF;
        last_rd[1] = 32'd0;
        legal_rd[0] = 3'b001; legal_rd[1] = 3'b010; legal_rd[2] = 3'b011;
        legal_rd[3] = 3'b101; legal_rd[4] = 3'b110;
        for (int t = 0; t < 300; t++) begin
            s3 = bit'($urandom_range(0, 1));
            k  = int'($urandom_range(0, 15));
            rr = 3'b000; rw = 2'b00;
            if (k <= 5)       rw = 2'(1 + k % 3);
            else if (k <= 12) rr = legal_rd[(k - 6) % 5];
            else if (k == 13) rr = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'b111;
            else if (k == 14) begin rr = legal_rd[$urandom_range(0, 4)]; rw = 2'(1 + $urandom_range(0, 2)); end
            ra_r = 32'h100 + 32'($urandom_range(0, 127));
            if ($urandom_range(0, 15) == 0) ra_r = ra_r | (32'd1 << $urandom_range(14, 31));
            rd_r = $urandom;

            if (rr == 3'b011 || rw == 2'b11)                          nb = 4;
            else if (rr == 3'b010 || rr == 3'b110 || rw == 2'b10)     nb = 2;
            else                                                      nb = 1;
            flt = ((rr != 3'b000) == (rw != 2'b00)) || (rr == 3'b100) || (rr == 3'b111) ||
                  ((ra_r % nb) != 0) || (ra_r >= 32'h4000);

            req(s3, rr, rw, ra_r, rd_r, g_en, g_we, g_ra, g_wd, g_rd, g_er, g_lat);
            ai = int'(ra_r[8:0]);
            exp_we = 4'h0;
            if (flt) begin
                exp_rd = 32'd0;
                chk($sformatf("rnd%0d.lat", t), 32'(g_lat), 32'd1);
            end else if (rw != 2'b00) begin
                exp_rd = last_rd[s3];
                for (int i = 0; i < nb; i++) begin
                    exp_we[(ai + i) % 4] = 1'b1;
                    refm[s3][ai + i] = rd_r[8*i +: 8];
                end
                chk($sformatf("rnd%0d.lat", t), 32'(g_lat), 32'd1);
            end else begin
                exp_rd = 32'd0;
                for (int i = 0; i < nb; i++) exp_rd = exp_rd | (32'(refm[s3][ai + i]) << (8 * i));
                if ((rr == 3'b001 || rr == 3'b010) && exp_rd[8*nb-1])
                    exp_rd = exp_rd | ~((32'd1 << (8 * nb)) - 32'd1);
                chk($sformatf("rnd%0d.lat", t), 32'(g_lat), s3 ? 32'd4 : 32'd2);
            end
            last_rd[s3] = exp_rd;
            chk($sformatf("rnd%0d.ram_en", t), {31'd0, g_en}, {31'd0, !flt});
            chk($sformatf("rnd%0d.ram_we", t), {28'd0, g_we}, {28'd0, exp_we});
            chk($sformatf("rnd%0d.bus_err", t), {31'd0, g_er}, {31'd0, flt});
            chk($sformatf("rnd%0d.rdata", t), g_rd, exp_rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
